// File: rtl/host_proto_pkg.sv
// Shared definitions for the host register-command protocol: frame magics,
// frame lengths, controller state encodings and the request frame layout.
// Used by reg_cmd_master and host_iface.
package host_proto_pkg;

  localparam logic [7:0] CMD_MAGIC = 8'hAA;
  localparam logic [7:0] RSP_MAGIC = 8'hAB;

  localparam int unsigned REQ_LEN         = 8;
  localparam int unsigned RSP_LEN         = 5;
  localparam int unsigned TIMEOUT_DEFAULT = 1024;

  localparam int unsigned ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [ST_W-1:0] ST_TX       = 3'd1;
  localparam logic [ST_W-1:0] ST_GAP      = 3'd2;
  localparam logic [ST_W-1:0] ST_RX_MAGIC = 3'd3;
  localparam logic [ST_W-1:0] ST_RX_DATA  = 3'd4;
  localparam logic [ST_W-1:0] ST_DONE     = 3'd5;

  // Request frame; magic is the first byte on the wire (LSB end).
  typedef struct packed {
    logic [31:0] value;
    logic [15:0] addr;
    logic [7:0]  wr;
    logic [7:0]  magic;
  } req_frame_t;

  function automatic logic [63:0] pack_request(input logic        write,
                                               input logic [15:0] addr,
                                               input logic [31:0] value);
    req_frame_t f;
    f.value = value;
    f.addr  = addr;
    f.wr    = {7'b0, write};
    f.magic = CMD_MAGIC;
    return f;
  endfunction

endpackage

// File: rtl/strobe_edge.sv
// Registered single-edge detector for a strobe already in the clk_i domain.
// Ports: clk_i, reset_i (sync, active high), strobe_i (level),
//        edge_c (combinational: rise when FALLING=0, fall when FALLING=1).
// RST_VAL is the strobe's idle level so no false edge follows reset.
module strobe_edge #(
  parameter bit FALLING = 1'b0,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic strobe_i,
  output logic edge_c
);

  logic prev_q;
  logic prev_d;

  always_comb prev_d = strobe_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) prev_q <= RST_VAL;
    else         prev_q <= prev_d;
  end

  assign edge_c = FALLING ? (prev_q & ~strobe_i) : (~prev_q & strobe_i);

endmodule

// File: rtl/reg_cmd_master.sv
// Register-command initiator: serializes a parallel command into the 8-byte
// request frame towards host_iface and collects the 0xAB-framed reply.
// Ports: clk_i/reset_i (sync, active high); cmd_* valid/ready command port;
//        rsp_* one-cycle response; nrxf_o/nrd_i/d_o/d_oe_o request byte
//        handshake; ntxe_o/wr_i/d_i reply byte handshake.
// Option: define REG_CMD_MASTER_TIMEOUT_EN to enable the reply timeout
//         (TIMEOUT_CYCLES parameter); otherwise rsp_timeout_o is tied low.
module reg_cmd_master
  import host_proto_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
)
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [15:0] cmd_addr_i,
  input  logic [31:0] cmd_value_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  output logic        nrxf_o,
  input  logic        nrd_i,
  output logic [7:0]  d_o,
  output logic        d_oe_o,
  output logic        ntxe_o,
  input  logic        wr_i,
  input  logic [7:0]  d_i
);

  // Parameter sanity check.
  if (TIMEOUT_CYCLES < 16) begin : g_bad_timeout
    $error("reg_cmd_master: TIMEOUT_CYCLES must be at least 16");
  end

  logic [ST_W-1:0] state_q, state_d;
  logic [55:0]     shreg_q, shreg_d;   // request bytes still to be sent
  logic [7:0]      d_q, d_d;
  logic [2:0]      idx_q, idx_d;
  logic [1:0]      rx_idx_q, rx_idx_d;
  logic            nrxf_q, nrxf_d;
  logic            ntxe_q, ntxe_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic [63:0]     req_c;
  logic            nrd_rise_c;
  logic            wr_fall_c;

`ifdef REG_CMD_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_timeout_q, rsp_timeout_d;
`endif

  strobe_edge #(.FALLING(1'b0), .RST_VAL(1'b1)) u_nrd_edge (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .strobe_i (nrd_i),
    .edge_c   (nrd_rise_c)
  );

  strobe_edge #(.FALLING(1'b1), .RST_VAL(1'b0)) u_wr_edge (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .strobe_i (wr_i),
    .edge_c   (wr_fall_c)
  );

  assign req_c = pack_request(cmd_write_i, cmd_addr_i, cmd_value_i);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    d_d         = d_q;
    idx_d       = idx_q;
    rx_idx_d    = rx_idx_q;
    nrxf_d      = nrxf_q;
    ntxe_d      = ntxe_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
`ifdef REG_CMD_MASTER_TIMEOUT_EN
    cnt_d         = cnt_q;
    rsp_timeout_d = rsp_timeout_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          d_d         = req_c[7:0];
          shreg_d     = req_c[63:8];
          idx_d       = 3'd0;
          rsp_err_d   = 1'b0;
          cmd_ready_d = 1'b0;
          nrxf_d      = 1'b0;
          state_d     = ST_TX;
`ifdef REG_CMD_MASTER_TIMEOUT_EN
          cnt_d         = '0;
          rsp_timeout_d = 1'b0;
`endif
        end
      end
      ST_TX: begin
        if (nrd_rise_c) begin
          idx_d  = idx_q + 3'd1;
          nrxf_d = 1'b1;
          if (idx_q == 3'(REQ_LEN - 1)) begin
            ntxe_d  = 1'b0;
            state_d = ST_RX_MAGIC;
          end else begin
            // Next byte is placed during the gap so it is stable when nrxf_o falls.
            d_d     = shreg_q[7:0];
            shreg_d = {8'h00, shreg_q[55:8]};
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        nrxf_d  = 1'b0;
        state_d = ST_TX;
      end
      ST_RX_MAGIC: begin
        if (wr_fall_c) begin
          rsp_err_d = (d_i != RSP_MAGIC);
          rx_idx_d  = 2'd0;
          state_d   = ST_RX_DATA;
        end
      end
      ST_RX_DATA: begin
        if (wr_fall_c) begin
          rsp_data_d[{rx_idx_q, 3'b000} +: 8] = d_i;
          rx_idx_d = rx_idx_q + 2'd1;
          if (rx_idx_q == 2'(RSP_LEN - 2)) begin
            rsp_valid_d = 1'b1;
            ntxe_d      = 1'b1;
            state_d     = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        cmd_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        nrxf_d      = 1'b1;
        ntxe_d      = 1'b1;
        cmd_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase

`ifdef REG_CMD_MASTER_TIMEOUT_EN
    // Inactivity counter, restarted by every byte moved in either direction.
    if (state_q == ST_TX || state_q == ST_GAP ||
        state_q == ST_RX_MAGIC || state_q == ST_RX_DATA) begin
      if ((state_q == ST_TX && nrd_rise_c) ||
          ((state_q == ST_RX_MAGIC || state_q == ST_RX_DATA) && wr_fall_c)) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        rsp_valid_d   = 1'b1;
        rsp_timeout_d = 1'b1;
        nrxf_d        = 1'b1;
        ntxe_d        = 1'b1;
        state_d       = ST_DONE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      d_q         <= '0;
      idx_q       <= '0;
      rx_idx_q    <= '0;
      nrxf_q      <= 1'b1;
      ntxe_q      <= 1'b1;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      d_q         <= d_d;
      idx_q       <= idx_d;
      rx_idx_q    <= rx_idx_d;
      nrxf_q      <= nrxf_d;
      ntxe_q      <= ntxe_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef REG_CMD_MASTER_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
  assign rsp_timeout_o = rsp_timeout_q;
`else
  assign rsp_timeout_o = 1'b0;
`endif

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign nrxf_o      = nrxf_q;
  assign ntxe_o      = ntxe_q;
  assign d_o         = d_q;
  // Bus is driven only while host_iface is actively reading a request byte.
  assign d_oe_o      = ((state_q == ST_TX) || (state_q == ST_GAP)) && !nrd_i;

endmodule
